// File: rtl/ft_tx_arbiter.sv
// ft_tx_arbiter: round-robin arbiter that merges two 16-bit requester streams
// into one FIFO write port (ft600_write), in bursts of at most MAX_BURST words.
// Each burst can be preceded by a header word 0xA5,src.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   sN_data/valid/last/ready requester N stream (N = 0,1), ready is combinational
//   fifo_din/fifo_din_valid  write word and 2-bit strobe (00 or 11), combinational
//   fifo_full/fifo_rst_busy  FIFO back-pressure; both low means space
//   grant                    one-hot owner of the current burst, 00 when idle
//   busy                     high while a burst is in progress
module ft_tx_arbiter #(
  parameter int unsigned MAX_BURST = 256,
  parameter bit          HEADER_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] s0_data,
  input  logic        s0_valid,
  input  logic        s0_last,
  output logic        s0_ready,
  input  logic [15:0] s1_data,
  input  logic        s1_valid,
  input  logic        s1_last,
  output logic        s1_ready,
  output logic [15:0] fifo_din,
  output logic [1:0]  fifo_din_valid,
  input  logic        fifo_full,
  input  logic        fifo_rst_busy,
  output logic [1:0]  grant,
  output logic        busy
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 16;
  localparam logic [7:0]  HDR_TAG = 8'hA5;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [1:0]         r_grant;
  logic               r_last_src;
  logic [CNT_W-1:0]   r_count;

  logic               w_space;
  logic               w_src;
  logic               w_any_req;
  logic               w_pick_s1;
  logic               w_g_valid;
  logic               w_g_last;
  logic [DATA_W-1:0]  w_g_data;
  logic               w_xfer;
  logic [CNT_W-1:0]   w_count_inc;
  logic               w_burst_end;

  // Owner-side views of the requester streams
  assign w_space     = ~fifo_full & ~fifo_rst_busy;
  assign w_src       = r_grant[1];
  assign w_g_valid   = w_src ? s1_valid : s0_valid;
  assign w_g_last    = w_src ? s1_last  : s0_last;
  assign w_g_data    = w_src ? s1_data  : s0_data;
  assign w_any_req   = s0_valid | s1_valid;
  // s1 wins when it is alone, or on a tie when s0 owned the previous burst
  assign w_pick_s1   = s1_valid & (~s0_valid | ~r_last_src);
  assign w_xfer      = (r_state == ST_DATA) & w_g_valid & w_space;
  assign w_count_inc = r_count + CNT_W'(1);
  assign w_burst_end = w_xfer & (w_g_last | (w_count_inc == MAX_CNT));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_any_req)   w_next_state = HEADER_EN ? ST_HDR : ST_DATA;
      ST_HDR:  if (w_space)     w_next_state = ST_DATA;
      ST_DATA: if (w_burst_end) w_next_state = ST_IDLE;
      default:                  w_next_state = ST_IDLE;
    endcase
  end

  // Burst owner, round-robin history and burst word counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant    <= 2'b00;
      r_last_src <= 1'b1;
      r_count    <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_any_req) begin
        r_grant <= {w_pick_s1, ~w_pick_s1};
        r_count <= '0;
      end
    end else if (w_xfer) begin
      r_count <= w_count_inc;
      if (w_burst_end) begin
        r_grant    <= 2'b00;
        r_last_src <= w_src;
      end
    end
  end

  // Output logic: header/data words pass straight through with no latency
  always_comb begin
    s0_ready       = 1'b0;
    s1_ready       = 1'b0;
    fifo_din       = '0;
    fifo_din_valid = 2'b00;
    case (r_state)
      ST_HDR: begin
        if (w_space) begin
          fifo_din       = {HDR_TAG, 7'd0, w_src};
          fifo_din_valid = 2'b11;
        end
      end
      ST_DATA: begin
        s0_ready = w_space & ~w_src;
        s1_ready = w_space &  w_src;
        if (w_xfer) begin
          fifo_din       = w_g_data;
          fifo_din_valid = 2'b11;
        end
      end
      default: ;
    endcase
  end

  assign grant = r_grant;
  assign busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ft_tx_arbiter.sv
// Bench for ft_tx_arbiter: two instances (header on / header off, both with
// MAX_BURST=4) driven from per-requester word queues, checked every cycle
// against an owner/count model and against hand-written FIFO stream tables.
module tb_ft_tx_arbiter;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst_n, fifo_full, fifo_rst_busy;
  logic [15:0] s_data  [2][2];
  logic        s_valid [2][2];
  logic        s_last  [2][2];
  logic        s_ready [2][2];
  logic [15:0] f_din   [2];
  logic [1:0]  f_dv    [2];
  logic [1:0]  grant   [2];
  logic        busy    [2];

  logic [16:0] q    [2][2][$];
  logic        hs   [2][2];
  logic [15:0] wlog [2][$];
  logic [15:0] glog [2][$];
  logic [15:0] exp_q[$];
  logic [1:0]  prev_g [2];
  int          wb, gb;

  int n_chk = 0;
  int n_pass = 0;

  // model state: owner (-1 idle), header pending, words sent, previous owner
  int   m_own [2];
  int   m_cnt [2];
  int   m_prev[2];
  logic m_hdr [2];
  logic sp, xf;
  logic [1:0]  e_g, e_dv;
  logic [15:0] e_din;
  logic        e_r [2];
  int          o;

  always #5 clk = ~clk;

  ft_tx_arbiter #(.MAX_BURST(MAXB), .HEADER_EN(1'b1)) u_dut_h (
    .clk(clk), .rst_n(rst_n),
    .s0_data(s_data[0][0]), .s0_valid(s_valid[0][0]), .s0_last(s_last[0][0]), .s0_ready(s_ready[0][0]),
    .s1_data(s_data[0][1]), .s1_valid(s_valid[0][1]), .s1_last(s_last[0][1]), .s1_ready(s_ready[0][1]),
    .fifo_din(f_din[0]), .fifo_din_valid(f_dv[0]), .fifo_full(fifo_full),
    .fifo_rst_busy(fifo_rst_busy), .grant(grant[0]), .busy(busy[0]));

  ft_tx_arbiter #(.MAX_BURST(MAXB), .HEADER_EN(1'b0)) u_dut_n (
    .clk(clk), .rst_n(rst_n),
    .s0_data(s_data[1][0]), .s0_valid(s_valid[1][0]), .s0_last(s_last[1][0]), .s0_ready(s_ready[1][0]),
    .s1_data(s_data[1][1]), .s1_valid(s_valid[1][1]), .s1_last(s_last[1][1]), .s1_ready(s_ready[1][1]),
    .fifo_din(f_din[1]), .fifo_din_valid(f_dv[1]), .fifo_full(fifo_full),
    .fifo_rst_busy(fifo_rst_busy), .grant(grant[1]), .busy(busy[1]));

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, got, want);
  endtask

  task automatic chk_q(string name, logic [15:0] got[$], int base, logic [15:0] want[$]);
    chk({name, "_len"}, 32'(got.size() - base), 32'(want.size()));
    for (int i = 0; i < want.size() && (base + i) < got.size(); i++)
      chk($sformatf("%s[%0d]", name, i), 32'(got[base+i]), 32'(want[i]));
  endtask

  task automatic drive();
    logic [16:0] w;
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 2; r++) begin
        if (q[d][r].size() != 0) begin
          w = q[d][r][0];
          s_valid[d][r] = 1'b1;
          s_data[d][r]  = w[15:0];
          s_last[d][r]  = w[16];
        end else begin
          s_valid[d][r] = 1'b0;
          s_data[d][r]  = 16'h0;
          s_last[d][r]  = 1'b0;
        end
      end
    end
  endtask

  task automatic push(int d, int r, logic [15:0] w, logic l);
    q[d][r].push_back({l, w});
    drive();
  endtask

  // advance one clock; words accepted at this edge leave their queues
  task automatic tick();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 2; r++)
        if (hs[d][r] && q[d][r].size() != 0) void'(q[d][r].pop_front());
    drive();
  endtask

  task automatic drain(int d, string name);
    int n = 0;
    while ((q[d][0].size() != 0 || q[d][1].size() != 0 || busy[d]) && n < 200) begin
      tick();
      n++;
    end
    chk(name, 32'({busy[d], q[d][0].size() != 0, q[d][1].size() != 0}), 32'd0);
  endtask

  task automatic mark(int d);
    wb = wlog[d].size();
    gb = glog[d].size();
  endtask

  task automatic wait_writes(int d, int n, string name);
    int c = 0;
    while ((wlog[d].size() - wb) < n && c < 50) begin
      tick();
      c++;
    end
    chk(name, 32'(wlog[d].size() - wb), 32'(n));
  endtask

  task automatic chk_zero(int d, string tag);
    chk({tag, "_grant"}, 32'(grant[d]), 32'd0);
    chk({tag, "_busy"},  32'(busy[d]),  32'd0);
    chk({tag, "_dv"},    32'(f_dv[d]),  32'd0);
    chk({tag, "_din"},   32'(f_din[d]), 32'd0);
    chk({tag, "_rdy0"},  32'(s_ready[d][0]), 32'd0);
    chk({tag, "_rdy1"},  32'(s_ready[d][1]), 32'd0);
  endtask

  // cycle compare against the model, sampled mid-cycle
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      sp = !fifo_full && !fifo_rst_busy;
      e_g = 2'b00; e_dv = 2'b00; e_din = 16'h0; e_r[0] = 1'b0; e_r[1] = 1'b0; xf = 1'b0;
      o = m_own[d];
      if (rst_n && o >= 0) begin
        e_g = (o == 0) ? 2'b01 : 2'b10;
        if (m_hdr[d]) begin
          if (sp) begin e_dv = 2'b11; e_din = 16'hA500 + 16'(o); end
        end else begin
          e_r[o] = sp;
          xf = sp && s_valid[d][o];
          if (xf) begin e_dv = 2'b11; e_din = s_data[d][o]; end
        end
      end
      chk($sformatf("d%0d_grant", d), 32'(grant[d]), 32'(e_g));
      chk($sformatf("d%0d_busy", d),  32'(busy[d]),  32'(e_g != 2'b00));
      chk($sformatf("d%0d_dv", d),    32'(f_dv[d]),  32'(e_dv));
      chk($sformatf("d%0d_din", d),   32'(f_din[d]), 32'(e_din));
      chk($sformatf("d%0d_rdy0", d),  32'(s_ready[d][0]), 32'(e_r[0]));
      chk($sformatf("d%0d_rdy1", d),  32'(s_ready[d][1]), 32'(e_r[1]));
      if (f_dv[d] == 2'b11) wlog[d].push_back(f_din[d]);
      if (grant[d] != 2'b00 && prev_g[d] == 2'b00) glog[d].push_back(16'(grant[d]));
      prev_g[d] = grant[d];
      hs[d][0] = s_valid[d][0] && s_ready[d][0];
      hs[d][1] = s_valid[d][1] && s_ready[d][1];
      if (!rst_n) begin
        m_own[d] = -1; m_hdr[d] = 1'b0; m_cnt[d] = 0; m_prev[d] = 1;
      end else if (o < 0) begin
        if (s_valid[d][0] || s_valid[d][1]) begin
          m_own[d] = (s_valid[d][0] && s_valid[d][1]) ? 1 - m_prev[d] : (s_valid[d][0] ? 0 : 1);
          m_hdr[d] = (d == 0);
          m_cnt[d] = 0;
        end
      end else if (m_hdr[d]) begin
        if (sp) m_hdr[d] = 1'b0;
      end else if (xf) begin
        m_cnt[d]++;
        if (s_last[d][o] || m_cnt[d] == MAXB) begin
          m_prev[d] = o;
          m_own[d]  = -1;
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; fifo_full = 1'b0; fifo_rst_busy = 1'b0;
    for (int d = 0; d < 2; d++) begin
      prev_g[d] = 2'b00; hs[d][0] = 1'b0; hs[d][1] = 1'b0;
    end
    drive();

    // reset holds everything at zero even with requests pending
    push(0, 0, 16'h1000, 1'b0); push(0, 0, 16'h1001, 1'b0); push(0, 0, 16'h1002, 1'b1);
    push(0, 1, 16'h2000, 1'b0); push(0, 1, 16'h2001, 1'b1);
    repeat (3) tick();
    chk_zero(0, "rst_h");
    chk_zero(1, "rst_n");

    // two packets, tie at start goes to s0
    mark(0);
    rst_n = 1'b1;
    drain(0, "t1_drain");
    exp_q = '{16'hA500, 16'h1000, 16'h1001, 16'h1002, 16'hA501, 16'h2000, 16'h2001};
    chk_q("t1_stream", wlog[0], wb, exp_q);
    exp_q = '{16'h0001, 16'h0002};
    chk_q("t1_grant", glog[0], gb, exp_q);

    // endless s0 stream cut every MAX_BURST words
    mark(0);
    for (int i = 0; i < 8; i++) push(0, 0, 16'h1100 + 16'(i), 1'b0);
    drain(0, "t2a_drain");
    exp_q = '{16'hA500, 16'h1100, 16'h1101, 16'h1102, 16'h1103,
              16'hA500, 16'h1104, 16'h1105, 16'h1106, 16'h1107};
    chk_q("t2a_stream", wlog[0], wb, exp_q);

    // s1 arriving mid-burst takes the next grant
    mark(0);
    for (int i = 0; i < 8; i++) push(0, 0, 16'h1200 + 16'(i), 1'b0);
    repeat (3) tick();
    push(0, 1, 16'h2200, 1'b1);
    drain(0, "t2b_drain");
    exp_q = '{16'hA500, 16'h1200, 16'h1201, 16'h1202, 16'h1203, 16'hA501, 16'h2200,
              16'hA500, 16'h1204, 16'h1205, 16'h1206, 16'h1207};
    chk_q("t2b_stream", wlog[0], wb, exp_q);
    exp_q = '{16'h0001, 16'h0002, 16'h0001};
    chk_q("t2b_grant", glog[0], gb, exp_q);

    // FIFO full for 5 cycles while word 2 is offered
    mark(0);
    for (int i = 0; i < 4; i++) push(0, 0, 16'h1300 + 16'(i), i == 3);
    wait_writes(0, 3, "t3_reach");
    fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_stall_dv", 32'(f_dv[0]), 32'd0);
      chk("t3_stall_rdy", 32'(s_ready[0][0]), 32'd0);
      tick();
    end
    fifo_full = 1'b0;
    drain(0, "t3_drain");
    exp_q = '{16'hA500, 16'h1300, 16'h1301, 16'h1302, 16'h1303};
    chk_q("t3_stream", wlog[0], wb, exp_q);

    // FIFO in reset when our reset releases: header waits
    rst_n = 1'b0; fifo_rst_busy = 1'b1;
    push(0, 1, 16'h2300, 1'b0); push(0, 1, 16'h2301, 1'b1);
    tick(); tick();
    mark(0);
    rst_n = 1'b1;
    repeat (4) tick();
    #1;
    chk("t4_grant", 32'(grant[0]), 32'h2);
    chk("t4_busy", 32'(busy[0]), 32'h1);
    chk("t4_dv", 32'(f_dv[0]), 32'h0);
    fifo_rst_busy = 1'b0;
    drain(0, "t4_drain");
    exp_q = '{16'hA501, 16'h2300, 16'h2301};
    chk_q("t4_stream", wlog[0], wb, exp_q);

    // reset mid-burst abandons it; arbitration restarts with s0
    mark(0);
    for (int i = 0; i < 4; i++) push(0, 0, 16'h1400 + 16'(i), i == 3);
    push(0, 1, 16'h2400, 1'b0); push(0, 1, 16'h2401, 1'b1);
    wait_writes(0, 2, "t5_reach");
    rst_n = 1'b0;
    #1;
    chk_zero(0, "t5_rst");
    tick(); tick();
    rst_n = 1'b1;
    drain(0, "t5_drain");
    exp_q = '{16'hA500, 16'h1400, 16'hA500, 16'h1401, 16'h1402, 16'h1403,
              16'hA501, 16'h2400, 16'h2401};
    chk_q("t5_stream", wlog[0], wb, exp_q);
    exp_q = '{16'h0001, 16'h0001, 16'h0002};
    chk_q("t5_grant", glog[0], gb, exp_q);

    // no header: single-word packets alternate owners
    mark(1);
    push(1, 0, 16'h3000, 1'b1); push(1, 0, 16'h3001, 1'b1);
    push(1, 1, 16'h4000, 1'b1); push(1, 1, 16'h4001, 1'b1);
    drain(1, "t6_drain");
    exp_q = '{16'h3000, 16'h4000, 16'h3001, 16'h4001};
    chk_q("t6_stream", wlog[1], wb, exp_q);
    exp_q = '{16'h0001, 16'h0002, 16'h0001, 16'h0002};
    chk_q("t6_grant", glog[1], gb, exp_q);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ft_tx_arbiter.md
FT_TX_ARBITER -- requirements
Module: ft_tx_arbiter

Interface
REQ-001 Parameter MAX_BURST, 256, maximum data words per granted burst (legal 1..65535).
REQ-002 Parameter HEADER_EN, 1, when 1 each burst is preceded by one header word.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 s0_data  in  16  requester 0 data word.
REQ-006 s0_valid  in  1  requester 0 word available.
REQ-007 s0_last  in  1  requester 0 word is last of its packet.
REQ-008 s0_ready  out  1  requester 0 word accepted this cycle when s0_valid also high.
REQ-009 s1_data, s1_valid, s1_last, s1_ready: same as REQ-005..008 for requester 1.
REQ-010 fifo_din  out  16  word to ft600_write din.
REQ-011 fifo_din_valid  out  2  byte-enable write strobe to ft600_write; only 2'b00 or 2'b11.
REQ-012 fifo_full  in  1  ft600_write full.
REQ-013 fifo_rst_busy  in  1  ft600_write reset busy.
REQ-014 grant  out  2  one-hot current burst owner; 2'b00 when idle.
REQ-015 busy  out  1  high whenever state is not IDLE.

Function
REQ-016 The block SHALL implement states IDLE, HDR, DATA.
REQ-017 "Space" SHALL mean fifo_full==0 and fifo_rst_busy==0, sampled in the same cycle.
REQ-018 In IDLE, if any sN_valid is high, the block SHALL grant one requester and move to HDR (HEADER_EN=1) or DATA (HEADER_EN=0) at the next edge.
REQ-019 Arbitration SHALL be round-robin: when both valid, the requester not granted last wins; when one valid, it wins.
REQ-020 IDLE SHALL last at least one cycle between bursts; no writes occur in IDLE.
REQ-021 In HDR, with space, the block SHALL drive fifo_din={8'hA5,7'b0,src} and fifo_din_valid=2'b11 for exactly one cycle, then enter DATA; without space it SHALL hold HDR with fifo_din_valid=2'b00.
REQ-022 In DATA, sN_ready of the granted requester SHALL equal space; the other requester's ready SHALL be 0.
REQ-023 A transfer occurs when granted sN_valid and sN_ready are both high; in that cycle fifo_din=sN_data and fifo_din_valid=2'b11 (combinational, zero latency).
REQ-024 In every non-transfer, non-header cycle fifo_din_valid SHALL be 2'b00; fifo_din is don't-care but SHALL be 0 in IDLE.
REQ-025 A 16-bit burst counter SHALL clear on grant and increment per data transfer.
REQ-026 The burst SHALL end on the transfer with sN_last=1 or the transfer making count==MAX_BURST, whichever comes first; next state IDLE and last-grant record updated to the owner.
REQ-027 A burst cut at MAX_BURST without last SHALL leave the remainder for a later grant; the requester re-competes under round-robin.
REQ-028 Granted requester deasserting valid mid-burst SHALL stall DATA indefinitely; grant is not revoked.
REQ-029 fifo_full or fifo_rst_busy rising mid-burst SHALL stall HDR/DATA with no word lost or duplicated; progress resumes the first cycle space returns.
REQ-030 sN_ready SHALL never be high in IDLE or HDR.
REQ-031 grant SHALL be stable from grant cycle through the burst-ending transfer cycle.

Reset
REQ-032 rst_n low SHALL immediately force state IDLE, grant=2'b00, busy=0, s0_ready=s1_ready=0, fifo_din=0, fifo_din_valid=2'b00, counter 0, last-grant=requester 1 (requester 0 wins first tie).
REQ-033 Reset asserted mid-burst SHALL abandon the burst; no partial state survives; after release arbitration restarts per REQ-032.

Verification
REQ-034 Both valid from reset, s0 packet 3 words (last on 3rd), s1 packet 2 words, HEADER_EN=1 -> FIFO stream A500, s0 w0..w2, A501, s1 w0..w1; grant 01 then 10.
REQ-035 s0 continuous, never last, MAX_BURST=4, s1 idle -> A500 + 4 words, IDLE cycle, A500 + 4 words repeating; s1 asserting valid mid-burst wins the next grant.
REQ-036 fifo_full high for 5 cycles during DATA word 2 -> fifo_din_valid=00 and s0_ready=0 for those 5 cycles, word 2 written once after release.
REQ-037 fifo_rst_busy high at reset release with s1 valid -> grant 10 issued, header held until rst_busy low, no write while busy.
REQ-038 rst_n pulled low during DATA word 1 of 4 -> outputs zero within same cycle, after release s0 (both valid) granted first, header reissued.
REQ-039 HEADER_EN=0, single-word packets alternating s0/s1 -> no A5xx words, one data word per burst, grant alternates each burst.
